controller: RTL and testbench

- Main decoder for the MIPS-subset CPU.
- Takes a 32-bit instruction word, decodes opcode/funct, and produces datapath control strobes plus a 3-bit ALU operation code.
- Outputs are registered: a decode-stage register feeding the execute/memory/writeback controls of the following cycle.

---
 rtl/controller_pkg.sv | 55 +++++
 rtl/controller_if.sv | 34 +++
 rtl/controller_decode.sv | 89 ++++++++
 rtl/controller.sv | 45 ++++
 tb/tb_controller.sv | 112 +++++++++++
 5 files changed

// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : controller_pkg
// Description : Shared opcode/funct/ALUOp encodings and the control bundle
//               type for the MIPS-subset main decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    gpr_write;
    logic    dm_write;
    logic    beq;
    logic    bgtz;
    logic    jal;
    logic    jr;
    logic    sign_ext;
    logic    lui_ext;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic [5:0] get_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] get_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/controller_if.sv
`default_nettype none
// ============================================================================
// Module      : controller_if
// Description : Instruction in / registered datapath controls out.
// Revision    : 1.0 - initial release
// ============================================================================
interface controller_if;
  logic [31:0] instr;
  logic        RegDst;
  logic        AluSrc;
  logic        MemToReg;
  logic        GPR_Write;
  logic        DM_Write;
  logic        beq;
  logic        bgtz;
  logic        jal;
  logic        jr;
  logic        SignExt;
  logic        LuiExt;
  logic [2:0]  ALUOp;

  modport master (
    output instr,
    input  RegDst, AluSrc, MemToReg, GPR_Write, DM_Write,
    input  beq, bgtz, jal, jr, SignExt, LuiExt, ALUOp
  );

  modport slave (
    input  instr,
    output RegDst, AluSrc, MemToReg, GPR_Write, DM_Write,
    output beq, bgtz, jal, jr, SignExt, LuiExt, ALUOp
  );
endinterface
`default_nettype wire

// File: rtl/controller_decode.sv
`default_nettype none
// ============================================================================
// Module      : controller_decode
// Description : Combinational opcode/funct decode into an unregistered
//               control bundle; unsupported encodings decode as NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module controller_decode
  import controller_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  // Register/immediate fields are consumed by the datapath, not the decoder.
  logic       w_unused_fields;

  assign w_opcode        = get_opcode(instr);
  assign w_funct         = get_funct(instr);
  assign w_unused_fields = ^instr[25:6];

  always_comb begin
    ctrl = CTRL_NOP;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.gpr_write = 1'b1;
            ctrl.alu_op    = ALU_ADD;
          end
          FN_SUBU: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.gpr_write = 1'b1;
            ctrl.alu_op    = ALU_SUB;
          end
          FN_JR: begin
            ctrl.jr = 1'b1;
          end
          default: ctrl = CTRL_NOP;
        endcase
      end
      OP_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.gpr_write = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      OP_LUI: begin
        // Shifted immediate is OR'd with $0 to form the result.
        ctrl.alu_src   = 1'b1;
        ctrl.gpr_write = 1'b1;
        ctrl.lui_ext   = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.gpr_write  = 1'b1;
        ctrl.sign_ext   = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src  = 1'b1;
        ctrl.dm_write = 1'b1;
        ctrl.sign_ext = 1'b1;
        ctrl.alu_op   = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.beq      = 1'b1;
        ctrl.sign_ext = 1'b1;
        ctrl.alu_op   = ALU_SUB;
      end
      OP_BGTZ: begin
        ctrl.bgtz     = 1'b1;
        ctrl.sign_ext = 1'b1;
        ctrl.alu_op   = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.jal       = 1'b1;
        ctrl.gpr_write = 1'b1;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/controller.sv
`default_nettype none
// ============================================================================
// Module      : controller
// Description : Main decoder with a one-cycle decode-stage output register.
// Revision    : 1.0 - initial release
// ============================================================================
module controller
  import controller_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  controller_if.slave  bus
);

  ctrl_t w_ctrl;
  ctrl_t r_ctrl;

  controller_decode u_decode (
    .instr (bus.instr),
    .ctrl  (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= CTRL_NOP;
    end else begin
      r_ctrl <= w_ctrl;
    end
  end

  assign bus.RegDst    = r_ctrl.reg_dst;
  assign bus.AluSrc    = r_ctrl.alu_src;
  assign bus.MemToReg  = r_ctrl.mem_to_reg;
  assign bus.GPR_Write = r_ctrl.gpr_write;
  assign bus.DM_Write  = r_ctrl.dm_write;
  assign bus.beq       = r_ctrl.beq;
  assign bus.bgtz      = r_ctrl.bgtz;
  assign bus.jal       = r_ctrl.jal;
  assign bus.jr        = r_ctrl.jr;
  assign bus.SignExt   = r_ctrl.sign_ext;
  assign bus.LuiExt    = r_ctrl.lui_ext;
  assign bus.ALUOp     = r_ctrl.alu_op;

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller
// Description : Directed self-checking bench for the registered main decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controller;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  controller_if bus ();

  controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {RegDst,AluSrc,MemToReg,GPR_Write,DM_Write,beq,bgtz,jal,jr,SignExt,LuiExt,ALUOp}
  localparam logic [13:0] E_NOP  = 14'b0_0_0_0_0_0_0_0_0_0_0_000;
  localparam logic [13:0] E_ORI  = 14'b0_1_0_1_0_0_0_0_0_0_0_010;
  localparam logic [13:0] E_LUI  = 14'b0_1_0_1_0_0_0_0_0_0_1_010;
  localparam logic [13:0] E_ADDU = 14'b1_0_0_1_0_0_0_0_0_0_0_000;
  localparam logic [13:0] E_SUBU = 14'b1_0_0_1_0_0_0_0_0_0_0_001;
  localparam logic [13:0] E_SW   = 14'b0_1_0_0_1_0_0_0_0_1_0_000;
  localparam logic [13:0] E_LW   = 14'b0_1_1_1_0_0_0_0_0_1_0_000;
  localparam logic [13:0] E_BEQ  = 14'b0_0_0_0_0_1_0_0_0_1_0_001;
  localparam logic [13:0] E_BGTZ = 14'b0_0_0_0_0_0_1_0_0_1_0_001;
  localparam logic [13:0] E_JAL  = 14'b0_0_0_1_0_0_0_1_0_0_0_000;
  localparam logic [13:0] E_JR   = 14'b0_0_0_0_0_0_0_0_1_0_0_000;

  logic [13:0] obs;
  assign obs = {bus.RegDst, bus.AluSrc, bus.MemToReg, bus.GPR_Write, bus.DM_Write,
                bus.beq, bus.bgtz, bus.jal, bus.jr, bus.SignExt, bus.LuiExt, bus.ALUOp};

  logic [13:0] sb_q[$];
  int checks   = 0;
  int failures = 0;

  // Drive one instruction for one cycle, then check what the register captured.
  task automatic step(input logic [31:0] ins, input logic rst,
                      input logic [13:0] exp, input string tag);
    logic [13:0] want;
    @(negedge clk);
    bus.instr = ins;
    reset     = rst;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
    checks++;
    assert (($countones(obs[8:5]) <= 1) && !(obs[10] && obs[9])) else begin
      failures++;
      $error("FAIL %s_exclusive observed=%b expected=at_most_one_strobe_no_dm_gpr", tag, obs);
    end
  endtask

  initial begin
    bus.instr = 32'h0000_0000;
    reset     = 1'b1;

    step(32'h3404_007b, 1'b1, E_NOP,  "reset0");
    step(32'h3404_007b, 1'b1, E_NOP,  "reset1");
    step(32'h3404_007b, 1'b0, E_ORI,  "ori_after_reset");

    step(32'h3404_007b, 1'b0, E_ORI,  "ori");
    step(32'h3c06_007b, 1'b0, E_LUI,  "lui");
    step(32'h0086_8021, 1'b0, E_ADDU, "addu");
    step(32'h0086_8023, 1'b0, E_SUBU, "subu");

    step(32'had05_0004, 1'b0, E_SW,   "sw");
    step(32'h8d04_0008, 1'b0, E_LW,   "lw");

    step(32'h1085_0001, 1'b0, E_BEQ,  "beq");
    step(32'h1C80_0002, 1'b0, E_BGTZ, "bgtz");
    step(32'h0C00_0C00, 1'b0, E_JAL,  "jal");
    step(32'h03E0_0008, 1'b0, E_JR,   "jr");

    step(32'h0000_0000, 1'b0, E_NOP,  "nop_zero");
    step(32'h0086_8022, 1'b0, E_NOP,  "nop_sub_funct");
    step(32'hFC00_0000, 1'b0, E_NOP,  "nop_op3f");

    step(32'h3404_007b, 1'b0, E_ORI,  "ori_pre_reset");
    step(32'h8d04_0008, 1'b1, E_NOP,  "lw_under_reset");
    step(32'h8d04_0008, 1'b0, E_LW,   "lw_after_reset");

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
